// File: rtl/logicnet_lut_pkg.sv
// Shared definitions for the LogicNet truth-table neuron array:
// controller state encoding and default array geometry.
package logicnet_lut_pkg;

    localparam int unsigned DEF_NEURONS  = 4;
    localparam int unsigned DEF_IN_BITS  = 8;
    localparam int unsigned DEF_OUT_BITS = 1;

    typedef enum logic [1:0] {
        CFG   = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } lut_state_t;

endpackage

// File: rtl/logicnet_lut_array_bank.sv
// One neuron: a 2^IN_BITS-entry truth table with its write port
// and the stage-2 lookup register that feeds the array output.
module logicnet_lut_bank #(
    parameter int unsigned IN_BITS  = 8,
    parameter int unsigned OUT_BITS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [IN_BITS-1:0]  waddr,
    input  logic [OUT_BITS-1:0] wdata,
    input  logic                ld,
    input  logic [IN_BITS-1:0]  raddr,
    output logic [OUT_BITS-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** IN_BITS;

    logic [OUT_BITS-1:0] mem [DEPTH];

    // Table is register-based so reset can clear every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            if (ld) begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/logicnet_lut_array.sv
// Array of NEURONS independent truth-table neurons behind a two-stage
// valid/ready pipeline, with a CFG/RUN/DRAIN table-load controller.
module logicnet_lut_array
    import logicnet_lut_pkg::*;
#(
    parameter int unsigned NEURONS  = DEF_NEURONS,
    parameter int unsigned IN_BITS  = DEF_IN_BITS,
    parameter int unsigned OUT_BITS = DEF_OUT_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [$clog2(NEURONS)-1:0]    cfg_neuron,
    input  logic [IN_BITS-1:0]            cfg_addr,
    input  logic [OUT_BITS-1:0]           cfg_data,
    input  logic                          cfg_commit,
    input  logic                          cfg_req,
    output logic                          cfg_ready,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NEURONS*IN_BITS-1:0]    in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NEURONS*OUT_BITS-1:0]   out_data
);

    localparam int unsigned NW = $clog2(NEURONS);
    localparam logic [NW:0] NLIM = (NW + 1)'(NEURONS);

    lut_state_t                  state;
    logic                        s1_valid;
    logic [NEURONS*IN_BITS-1:0]  s1_data;
    logic                        s2_valid;
    logic                        s2_load;
    logic                        accept;
    logic                        cfg_wr_ok;
    logic [OUT_BITS-1:0]         bank_q [NEURONS];

    // Stage 2 takes stage 1 whenever it is empty or its beat is leaving.
    assign s2_load   = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = (state == RUN) && (!s1_valid || s2_load);
    assign accept    = in_valid && in_ready;
    assign cfg_ready = (state == CFG);
    assign out_valid = s2_valid;
    assign cfg_wr_ok = (state == CFG) && cfg_we && ({1'b0, cfg_neuron} < NLIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CFG;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
        end else begin
            case (state)
                CFG:     if (cfg_commit) state <= RUN;
                RUN:     if (cfg_req) state <= DRAIN;
                DRAIN:   if (!s1_valid && !s2_valid) state <= CFG;
                default: state <= CFG;
            endcase

            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= in_data;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                s2_valid <= 1'b1;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    for (genvar n = 0; n < NEURONS; n++) begin : g_bank
        logicnet_lut_bank #(
            .IN_BITS  (IN_BITS),
            .OUT_BITS (OUT_BITS)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (cfg_wr_ok && (cfg_neuron == NW'(n))),
            .waddr (cfg_addr),
            .wdata (cfg_data),
            .ld    (s2_load),
            .raddr (s1_data[n*IN_BITS +: IN_BITS]),
            .rdata (bank_q[n])
        );
    end

    always_comb begin
        out_data = '0;
        for (int unsigned n = 0; n < NEURONS; n++) begin
            out_data[n*OUT_BITS +: OUT_BITS] = bank_q[n];
        end
    end

endmodule

// File: tb/tb_logicnet_lut_array.sv
// Randomized self-checking bench for logicnet_lut_array against a
// table-array reference model; NEURONS=3 so an out-of-range index is drivable.
module tb_logicnet_lut_array;

    localparam int NEU = 3;
    localparam int IB  = 8;
    localparam int OB  = 2;
    localparam int DW  = NEU * IB;
    localparam int OW  = NEU * OB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_neuron = '0;
    logic [IB-1:0] cfg_addr = '0;
    logic [OB-1:0] cfg_data = '0;
    logic          cfg_commit = 1'b0;
    logic          cfg_req = 1'b0;
    logic          cfg_ready;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] out_data;

    int total = 0;
    int bad   = 0;
    bit in_cfg = 1'b1;
    logic [OB-1:0] ref_tbl [NEU][256];

    logicnet_lut_array #(
        .NEURONS  (NEU),
        .IN_BITS  (IB),
        .OUT_BITS (OB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_neuron (cfg_neuron),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .cfg_req    (cfg_req),
        .cfg_ready  (cfg_ready),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] model(input logic [DW-1:0] d);
        logic [OW-1:0] r;
        r = '0;
        for (int n = 0; n < NEU; n++) r[n*OB +: OB] = ref_tbl[n][d[n*IB +: IB]];
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        return DW'($urandom());
    endfunction

    task automatic clear_model();
        for (int n = 0; n < NEU; n++)
            for (int a = 0; a < 256; a++) ref_tbl[n][a] = '0;
    endtask

    // Model follows the spec: writes land only in CFG and only for valid neurons.
    task automatic cfg_write(input int n, input int a, input int d, input bit we, input bit cmt);
        @(negedge clk);
        cfg_we = we; cfg_neuron = 2'(n); cfg_addr = 8'(a); cfg_data = 2'(d); cfg_commit = cmt;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_commit = 1'b0;
        if (we && in_cfg && n < NEU) ref_tbl[n][a] = 2'(d);
        if (cmt && in_cfg) in_cfg = 1'b0;
    endtask

    // Offers one beat to an idle pipeline; reports cycles until out_valid (-1 if none).
    task automatic run_beat(input logic [DW-1:0] d, output int lat, output logic [OW-1:0] q);
        bit acc;
        lat = -1; q = '0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; out_ready = 1'b1; #1;
        for (int k = 0; k < 8 && !in_ready; k++) begin @(negedge clk); #1; end
        acc = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 8 && acc && lat < 0; k++) begin
            @(negedge clk); #1;
            if (out_valid) begin lat = k; q = out_data; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
        rst = 1'b0;
        clear_model(); in_cfg = 1'b1;
        @(negedge clk); #1;
        total++; if (cfg_ready !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL post_reset: got cfg_ready=%b in_ready=%b out_valid=%b want 1 0 0", cfg_ready, in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [OW-1:0] q, e;
        logic [DW-1:0] d;
        for (int a = 0; a < 256; a++) cfg_write(0, a, (a < 128) ? 1 : 0, 1'b1, 1'b0);
        cfg_write(1, 255, 2, 1'b1, 1'b1);   // write in the commit cycle must land
        total++; if (cfg_ready !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL commit_state: got cfg_ready=%b in_ready=%b want 0 1", cfg_ready, in_ready);
        end
        for (int i = 0; i < 2; i++) begin
            d = rand_word();
            d[7:0] = (i == 0) ? 8'h05 : 8'h80;
            d[15:8] = 8'hFF;
            e = model(d);
            run_beat(d, lat, q);
            total++; if (lat != 2) begin bad++; $display("FAIL basic_latency: got %0d want 2", lat); end
            total++; if (q !== e) begin bad++; $display("FAIL basic_data: got %h want %h", q, e); end
            total++; if (q[0] !== ((i == 0) ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL basic_bit0: got %b want %b", q[0], (i == 0) ? 1'b1 : 1'b0);
            end
        end
    endtask

    task automatic test_run_write();
        int lat;
        logic [OW-1:0] q;
        cfg_write(1, 0, 1, 1'b1, 1'b0);
        run_beat('0, lat, q);
        total++; if (lat != 2 || q !== 6'b00_00_01) begin
            bad++; $display("FAIL run_write_ignored: got lat=%0d data=%h want lat=2 data=01", lat, q);
        end
    endtask

    task automatic test_reconfig();
        logic [DW-1:0] d;
        logic [OW-1:0] e, q;
        int nout, cfg_k;
        bit irdy_bad, order_bad;
        nout = 0; cfg_k = -1; irdy_bad = 0; order_bad = 0; q = '0;
        d = rand_word(); e = model(d);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; cfg_req = 1'b1; out_ready = 1'b1; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reconfig_accept: got %b want 1", in_ready); end
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); cfg_req = 1'b0; #1;
            if (in_ready !== 1'b0) irdy_bad = 1;
            if (out_valid) begin nout++; q = out_data; if (cfg_k >= 0) order_bad = 1; end
            if (cfg_ready && cfg_k < 0) cfg_k = k;
        end
        in_valid = 1'b0;
        in_cfg = 1'b1;
        total++; if (nout != 1 || q !== e) begin bad++; $display("FAIL reconfig_beat: got n=%0d data=%h want n=1 data=%h", nout, q, e); end
        total++; if (cfg_k != 4 || order_bad) begin bad++; $display("FAIL reconfig_cfg_ready: got cycle=%0d order_bad=%0d want 4 0", cfg_k, order_bad); end
        total++; if (irdy_bad) begin bad++; $display("FAIL reconfig_in_ready: got 1 want 0"); end
    endtask

    task automatic test_load_and_guard();
        int lat;
        logic [OW-1:0] q, e;
        logic [DW-1:0] d;
        for (int n = 0; n < NEU; n++)
            for (int a = 0; a < 256; a++) cfg_write(n, a, $urandom_range(0, 3), 1'b1, 1'b0);
        cfg_write(3, 0, 3, 1'b1, 1'b1);     // out-of-range neuron, commit same cycle
        for (int i = 0; i < 4; i++) begin
            d = (i == 0) ? '0 : rand_word();
            e = model(d);
            run_beat(d, lat, q);
            total++; if (lat != 2 || q !== e) begin
                bad++; $display("FAIL guard_lookup: got lat=%0d data=%h want lat=2 data=%h", lat, q, e);
            end
        end
    endtask

    task automatic test_stream(input int n, input bit toggle);
        logic [OW-1:0] exp_q[$];
        logic [OW-1:0] prev_q, e;
        logic [DW-1:0] cur;
        int sent, got, cyc;
        bit prev_stall;
        sent = 0; got = 0; cyc = 0; prev_stall = 0; prev_q = '0;
        cur = rand_word();
        while (got < n && cyc < n * 4 + 20) begin
            @(negedge clk);
            in_valid = (sent < n); in_data = cur;
            out_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            #1;
            if (prev_stall) begin
                total++; if (out_valid !== 1'b1 || out_data !== prev_q) begin
                    bad++; $display("FAIL stall_hold: got v=%b data=%h want v=1 data=%h", out_valid, out_data, prev_q);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL stream_extra: got data=%h want no beat", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin bad++; $display("FAIL stream_data[%0d]: got %h want %h", got, out_data, e); end
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_q = out_data;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(cur));
                sent++;
                cur = rand_word();
            end
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (got != n) begin bad++; $display("FAIL stream_count: got %0d want %0d", got, n); end
        if (!toggle) begin
            total++; if (cyc != n + 2) begin bad++; $display("FAIL stream_bubbles: got %0d cycles want %0d", cyc, n + 2); end
        end
    endtask

    task automatic test_reset_midstream();
        int lat, quiet_bad;
        logic [OW-1:0] q;
        quiet_bad = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); in_valid = 1'b1; in_data = rand_word();
        end
        @(negedge clk); in_valid = 1'b0; #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL inflight_before_rst: got %b want 1", out_valid); end
        rst = 1'b1; #1;
        total++; if (out_valid !== 1'b0 || out_data !== '0) begin
            bad++; $display("FAIL midrst_out: got v=%b data=%h want 0 0", out_valid, out_data);
        end
        total++; if (cfg_ready !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL midrst_ctrl: got cfg_ready=%b in_ready=%b want 1 0", cfg_ready, in_ready);
        end
        @(negedge clk); rst = 1'b0; out_ready = 1'b1;
        clear_model(); in_cfg = 1'b1;
        for (int k = 0; k < 4; k++) begin @(negedge clk); #1; if (out_valid !== 1'b0) quiet_bad++; end
        total++; if (quiet_bad != 0) begin bad++; $display("FAIL midrst_quiet: got %0d valid cycles want 0", quiet_bad); end
        cfg_write(0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_beat(rand_word(), lat, q);
            total++; if (lat != 2 || q !== '0) begin
                bad++; $display("FAIL midrst_cleared: got lat=%0d data=%h want lat=2 data=00", lat, q);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_run_write();
        test_reconfig();
        test_load_and_guard();
        test_stream(256, 1'b0);
        test_stream(20, 1'b1);
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
